// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants, state type and row-wrap helper for the text console
// Purpose: control-code constants, the console FSM state type, the default cell attribute,
//          and the modular add used for circular row addressing.
// Ports:   none (package).
package vga_text_pkg;

  localparam logic [7:0] C_BS    = 8'h08;
  localparam logic [7:0] C_TAB   = 8'h09;
  localparam logic [7:0] C_LF    = 8'h0A;
  localparam logic [7:0] C_FF    = 8'h0C;
  localparam logic [7:0] C_CR    = 8'h0D;
  localparam logic [7:0] C_SPACE = 8'h20;
  localparam logic [7:0] C_TILDE = 8'h7E;

  localparam logic [7:0] DEFAULT_ATTR = 8'h0F;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_ROW
  } state_t;

  // (a + b) mod m for operands already below m; a compare-and-subtract, no divider.
  function automatic int wrap_add(input int a, input int b, input int m);
    return (a + b >= m) ? a + b - m : a + b;
  endfunction

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - simple dual-port character RAM with a registered read port
// Purpose: screen storage, one write port and one synchronous read port (old data on collision).
// Ports:   clk            clock
//          we/waddr/wdata write port
//          raddr          read address, rdata valid one cycle later
//          rdata          registered read data
module text_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 50,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or the read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[IDX_W'(waddr)] <= wdata;
    rdata <= mem[IDX_W'(raddr)];
  end

endmodule

// File: rtl/vga_text_console.sv
// rtl/vga_text_console.sv - character grid manager with cursor, control codes and hardware scroll
// Purpose: accepts {attr,ascii} words, interprets control codes, keeps the cursor, stores the
//          screen in a circular row buffer and serves the glyph renderer by logical (row,col).
// Ports:   clk_pix, rst_n                 pixel clock, async active-low reset
//          wr_data/wr_valid/wr_ready      character input handshake
//          rd_row/rd_col -> rd_char/rd_attr  renderer read port, 1-cycle latency
//          cursor_row/cursor_col          registered logical cursor position
module vga_text_console #(
  parameter int GRID_COL    = 10,
  parameter int GRID_ROW    = 5,
  parameter int ASCII_WIDTH = 8,
  parameter int ATTR_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 11,
  parameter int TAB_WIDTH   = 4,
  parameter logic [ATTR_WIDTH-1:0] DEFAULT_ATTR = vga_text_pkg::DEFAULT_ATTR,
  localparam int ROW_W = (GRID_ROW > 1) ? $clog2(GRID_ROW) : 1,
  localparam int COL_W = (GRID_COL > 1) ? $clog2(GRID_COL) : 1
) (
  input  logic                            clk_pix,
  input  logic                            rst_n,
  input  logic [ATTR_WIDTH+ASCII_WIDTH-1:0] wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ROW_W-1:0]                rd_row,
  input  logic [COL_W-1:0]                rd_col,
  output logic [ASCII_WIDTH-1:0]          rd_char,
  output logic [ATTR_WIDTH-1:0]           rd_attr,
  output logic [ROW_W-1:0]                cursor_row,
  output logic [COL_W-1:0]                cursor_col
);

  import vga_text_pkg::*;

  localparam int DATA_W = ATTR_WIDTH + ASCII_WIDTH;
  localparam int CELLS  = GRID_ROW * GRID_COL;
  localparam logic [ASCII_WIDTH-1:0] SPACE_CH = ASCII_WIDTH'(C_SPACE);
  localparam logic [DATA_W-1:0]      BLANK    = {DEFAULT_ATTR, SPACE_CH};

  state_t                  state, state_n;
  logic [ROW_W-1:0]        row_q, row_n, base_q, base_n, clr_row_q, clr_row_n;
  logic [COL_W-1:0]        col_q, col_n;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_n;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr, ram_raddr;
  logic [DATA_W-1:0]       ram_wdata, ram_rdata;
  logic [ASCII_WIDTH-1:0]  code;
  logic                    advance;
  logic [ROW_W-1:0]        tgt_row;
  logic [COL_W-1:0]        tgt_col;
  int                      tab_next;
  logic                    rd_oob, rd_blank_q;

  // Logical row -> physical row through the scroll base, then row-major cell address.
  function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [ROW_W-1:0] lrow,
                                                       input logic [COL_W-1:0] c,
                                                       input logic [ROW_W-1:0] b);
    cell_addr = ADDR_WIDTH'(wrap_add(int'(lrow), int'(b), GRID_ROW)) * ADDR_WIDTH'(GRID_COL)
              + ADDR_WIDTH'(c);
  endfunction

  assign code = wr_data[ASCII_WIDTH-1:0];

  always_comb begin
    state_n   = state;
    row_n     = row_q;
    col_n     = col_q;
    base_n    = base_q;
    clr_row_n = clr_row_q;
    clr_cnt_n = clr_cnt_q;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = BLANK;
    advance   = 1'b0;
    tgt_row   = row_q;
    tgt_col   = col_q;
    tab_next  = (int'(col_q) / TAB_WIDTH + 1) * TAB_WIDTH;
    case (state)
      CLEAR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        clr_cnt_n = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == ADDR_WIDTH'(CELLS - 1)) begin
          clr_cnt_n = '0;
          state_n   = IDLE;
        end
      end
      CLEAR_ROW: begin
        ram_we    = 1'b1;
        ram_waddr = ADDR_WIDTH'(clr_row_q) * ADDR_WIDTH'(GRID_COL) + clr_cnt_q;
        clr_cnt_n = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == ADDR_WIDTH'(GRID_COL - 1)) begin
          clr_cnt_n = '0;
          state_n   = IDLE;
        end
      end
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          if (code >= SPACE_CH && code <= ASCII_WIDTH'(C_TILDE)) begin
            ram_we    = 1'b1;
            ram_wdata = wr_data;
            if (col_q == COL_W'(GRID_COL - 1)) begin
              col_n   = '0;
              advance = 1'b1;
            end else begin
              col_n = col_q + COL_W'(1);
            end
          end else if (code == ASCII_WIDTH'(C_LF)) begin
            col_n   = '0;
            advance = 1'b1;
          end else if (code == ASCII_WIDTH'(C_CR)) begin
            col_n = '0;
          end else if (code == ASCII_WIDTH'(C_BS)) begin
            // Erased cell takes the default attribute, same as a cleared cell.
            if (col_q != '0) begin
              tgt_col = col_q - COL_W'(1);
              col_n   = tgt_col;
              ram_we  = 1'b1;
            end else if (row_q != '0) begin
              tgt_row = row_q - ROW_W'(1);
              tgt_col = COL_W'(GRID_COL - 1);
              row_n   = tgt_row;
              col_n   = tgt_col;
              ram_we  = 1'b1;
            end
          end else if (code == ASCII_WIDTH'(C_TAB)) begin
            if (tab_next >= GRID_COL) begin
              col_n   = '0;
              advance = 1'b1;
            end else begin
              col_n = COL_W'(tab_next);
            end
          end else if (code == ASCII_WIDTH'(C_FF)) begin
            base_n    = '0;
            row_n     = '0;
            col_n     = '0;
            clr_cnt_n = '0;
            state_n   = CLEAR_ALL;
          end
          ram_waddr = cell_addr(tgt_row, tgt_col, base_q);
        end
      end
      default: state_n = CLEAR_ALL;
    endcase
    if (advance) begin
      if (row_q != ROW_W'(GRID_ROW - 1)) begin
        row_n = row_q + ROW_W'(1);
      end else begin
        // The new bottom logical row lands on the old top physical row, i.e. the old base.
        base_n    = ROW_W'(wrap_add(int'(base_q), 1, GRID_ROW));
        clr_row_n = base_q;
        clr_cnt_n = '0;
        state_n   = CLEAR_ROW;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ALL;
      row_q      <= '0;
      col_q      <= '0;
      base_q     <= '0;
      clr_row_q  <= '0;
      clr_cnt_q  <= '0;
      rd_blank_q <= 1'b1;
    end else begin
      state      <= state_n;
      row_q      <= row_n;
      col_q      <= col_n;
      base_q     <= base_n;
      clr_row_q  <= clr_row_n;
      clr_cnt_q  <= clr_cnt_n;
      rd_blank_q <= rd_oob;
    end
  end

  // Out-of-range requests are answered with a blank cell; the flag travels with the RAM latency.
  assign rd_oob    = (int'(rd_row) >= GRID_ROW) || (int'(rd_col) >= GRID_COL);
  assign ram_raddr = rd_oob ? '0 : cell_addr(rd_row, rd_col, base_q);

  text_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk_pix),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign rd_char    = rd_blank_q ? SPACE_CH : ram_rdata[ASCII_WIDTH-1:0];
  assign rd_attr    = rd_blank_q ? DEFAULT_ATTR : ram_rdata[DATA_W-1:ASCII_WIDTH];
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_vga_text_console.sv
// tb/tb_vga_text_console.sv - bench for vga_text_console against a logical-screen model
module tb_vga_text_console;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  rd_row;
  logic [3:0]  rd_col;
  logic [7:0]  rd_char;
  logic [7:0]  rd_attr;
  logic [2:0]  cursor_row;
  logic [3:0]  cursor_col;

  always #5 clk = ~clk;

  vga_text_console dut (
    .clk_pix    (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_char    (rd_char),
    .rd_attr    (rd_attr),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the screen as seen logically; scrolling moves rows up, no base pointer.
  logic [15:0] m_scr [5][10];
  bit          m_known [5][10];
  int          m_r, m_c, m_busy, m_mode;
  bit          m_acc;
  int          exp_ready, exp_row, exp_col;
  logic [15:0] exp_rd;
  bit          exp_rd_known = 0;
  bit          chk_en = 0;

  task automatic m_forget();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 10; c++) m_known[r][c] = 0;
  endtask

  task automatic m_adv();
    logic [15:0] tv [10];
    bit          tk [10];
    if (m_r < 4) begin
      m_r++;
    end else begin
      for (int c = 0; c < 10; c++) begin tv[c] = m_scr[0][c]; tk[c] = m_known[0][c]; end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 10; c++) begin
          m_scr[r][c] = m_scr[r+1][c];
          m_known[r][c] = m_known[r+1][c];
        end
      for (int c = 0; c < 10; c++) begin m_scr[4][c] = tv[c]; m_known[4][c] = tk[c]; end
      m_busy = 10;
      m_mode = 1;
    end
  endtask

  task automatic m_blank(input int r, input int c);
    m_scr[r][c] = 16'h0F20;
    m_known[r][c] = 1;
  endtask

  task automatic m_code(input logic [15:0] w);
    int ch;
    int n;
    ch = int'(w[7:0]);
    if (ch >= 32 && ch <= 126) begin
      m_scr[m_r][m_c] = w;
      m_known[m_r][m_c] = 1;
      if (m_c == 9) begin m_c = 0; m_adv(); end
      else m_c++;
    end else if (ch == 10) begin
      m_c = 0; m_adv();
    end else if (ch == 13) begin
      m_c = 0;
    end else if (ch == 8) begin
      if (m_c > 0) begin m_c--; m_blank(m_r, m_c); end
      else if (m_r > 0) begin m_r--; m_c = 9; m_blank(m_r, m_c); end
    end else if (ch == 9) begin
      n = (m_c / 4 + 1) * 4;
      if (n >= 10) begin m_c = 0; m_adv(); end
      else m_c = n;
    end else if (ch == 12) begin
      m_r = 0; m_c = 0; m_busy = 50; m_mode = 0; m_forget();
    end
  endtask

  task automatic m_step();
    int r;
    int c;
    int idx;
    r = int'(rd_row);
    c = int'(rd_col);
    if (r >= 5 || c >= 10) begin
      exp_rd = 16'h0F20; exp_rd_known = 1;
    end else begin
      exp_rd = m_scr[r][c]; exp_rd_known = m_known[r][c];
    end
    m_acc = 0;
    if (!rst_n) begin
      m_r = 0; m_c = 0; m_busy = 50; m_mode = 0; m_forget();
      exp_rd = 16'h0F20; exp_rd_known = 1;
    end else if (m_busy > 0) begin
      if (m_mode == 0) begin
        idx = 50 - m_busy;
        m_blank(idx / 10, idx % 10);
      end else begin
        m_blank(4, 10 - m_busy);
      end
      m_busy--;
    end else if (wr_valid) begin
      m_acc = 1;
      m_code(wr_data);
    end
    exp_ready = (m_busy == 0) ? 1 : 0;
    exp_row = m_r;
    exp_col = m_c;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_ready", int'(wr_ready), exp_ready);
      check("cursor_row", int'(cursor_row), exp_row);
      check("cursor_col", int'(cursor_col), exp_col);
      if (exp_rd_known) check("rd_cell", int'({rd_attr, rd_char}), int'(exp_rd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic rand_rd();
    rd_row = 3'($urandom_range(0, 5));
    rd_col = 4'($urandom_range(0, 10));
  endtask

  task automatic send(input logic [15:0] w, output int n);
    wr_data = w;
    wr_valid = 1'b1;
    n = 0;
    do begin
      rand_rd();
      cyc();
      n++;
    end while (!m_acc && n < 300);
    if (!m_acc) check("send_timeout", 0, 1);
    wr_valid = 1'b0;
  endtask

  task automatic put(input logic [15:0] w);
    int n;
    send(w, n);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (!wr_ready && n < 300) begin
      rand_rd();
      cyc();
      n++;
    end
  endtask

  task automatic read_cell(input int r, input int c, output int v);
    rd_row = 3'(r);
    rd_col = 4'(c);
    cyc();
    v = int'({rd_attr, rd_char});
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, int'(cursor_row), r);
    check({name, "_col"}, int'(cursor_col), c);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int v;
    int k;
    logic [7:0] others [6];
    others[0] = 8'h00; others[1] = 8'h01; others[2] = 8'h7F;
    others[3] = 8'h80; others[4] = 8'hFF; others[5] = 8'h1B;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_row = '0; rd_col = '0;

    // Reset state and initial clear
    cyc();
    chk_en = 1;
    check("reset_rd", int'({rd_attr, rd_char}), 16'h0F20);
    check("reset_ready", int'(wr_ready), 0);
    check_cursor("reset_cursor", 0, 0);
    cyc();
    rst_n = 1'b1;
    wait_busy(n);
    check("reset_busy_cycles", n, 50);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 10; c++) begin
        read_cell(r, c, v);
        check("blank_after_reset", v, 16'h0F20);
      end
    read_cell(6, 3, v);
    check("oob_row", v, 16'h0F20);
    read_cell(2, 12, v);
    check("oob_col", v, 16'h0F20);

    // Two printables
    put(16'h1F41);
    put(16'h1F42);
    check_cursor("ab_cursor", 0, 2);
    read_cell(0, 0, v); check("cell_0_0", v, 16'h1F41);
    read_cell(0, 1, v); check("cell_0_1", v, 16'h1F42);

    // Wrap and tabs
    put(16'h0F0D);
    for (int i = 0; i < 10; i++) put({8'h07, 8'(8'h30 + i)});
    check_cursor("wrap_cursor", 1, 0);
    read_cell(0, 9, v); check("cell_0_9", v, 16'h0739);
    put(16'h0009); put(16'h0009);
    check_cursor("tab2_cursor", 1, 8);
    put(16'h0009);
    check_cursor("tab3_cursor", 2, 0);

    // Fill the screen and scroll
    put(16'h000C);
    wait_busy(n);
    check("ff_busy_cycles", n, 50);
    for (int i = 0; i < 43; i++) put({8'h0F, 8'(8'h61 + i / 10)});
    check_cursor("fill_cursor", 4, 3);
    put(16'h000A);
    wait_busy(n);
    check("scroll_busy_cycles", n, 10);
    read_cell(0, 0, v); check("scrolled_row0", v, 16'h0F62);
    read_cell(3, 2, v); check("scrolled_row3", v, 16'h0F65);
    for (int c = 0; c < 10; c++) begin
      read_cell(4, c, v);
      check("scrolled_row4_blank", v, 16'h0F20);
    end
    check_cursor("scroll_cursor", 4, 0);

    // Backspace
    put(16'h000C);
    wait_busy(n);
    for (int i = 0; i < 10; i++) put({8'h2E, 8'(8'h4B + i)});
    check_cursor("bs_pre_cursor", 1, 0);
    put(16'h5508);
    check_cursor("bs_cursor", 0, 9);
    read_cell(0, 9, v); check("bs_cell", v, 16'h0F20);
    put(16'h000C);
    wait_busy(n);
    send(16'h0008, n);
    check("bs_origin_accept_cycles", n, 1);
    check_cursor("bs_origin_cursor", 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      if (k < 70)      put({8'($urandom), 8'($urandom_range(32, 126))});
      else if (k < 78) put({8'($urandom), 8'h0A});
      else if (k < 83) put({8'($urandom), 8'h0D});
      else if (k < 90) put({8'($urandom), 8'h08});
      else if (k < 96) put({8'($urandom), 8'h09});
      else if (k < 97) put({8'($urandom), 8'h0C});
      else             put({8'($urandom), others[$urandom_range(0, 5)]});
      if ($urandom_range(0, 3) == 0) begin
        rd_row = 3'($urandom_range(0, 7));
        rd_col = 4'($urandom_range(0, 15));
        cyc();
      end
    end

    // Form feed mid-screen, then reset during a row clear
    wait_busy(n);
    put(16'h0F0D);
    put(16'h0F0A);
    put(16'h3A5A);
    put(16'h000C);
    wait_busy(n);
    check("ff_mid_busy_cycles", n, 50);
    read_cell(1, 0, v); check("ff_mid_blank", v, 16'h0F20);
    check_cursor("ff_mid_cursor", 0, 0);
    for (int i = 0; i < 5; i++) put(16'h000A);
    check("row_clear_busy", int'(wr_ready), 0);
    cyc(); cyc(); cyc();
    #1 rst_n = 1'b0;
    #1;
    check("midreset_rd", int'({rd_attr, rd_char}), 16'h0F20);
    check("midreset_ready", int'(wr_ready), 0);
    check_cursor("midreset_cursor", 0, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    wait_busy(n);
    check("midreset_clear_cycles", n, 50);
    read_cell(4, 9, v); check("midreset_blank", v, 16'h0F20);
    put(16'h2C21);
    read_cell(0, 0, v); check("post_reset_write", v, 16'h2C21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
